// File: rtl/sc_chain_loader.sv
// rtl/sc_chain_loader.sv - configuration scan-chain bitstream writer with readback parity
//
// Accepts configuration words over a valid/ready handshake and shifts them
// LSB-first into the head of the scan chain. The bits falling out of the
// chain tail are XOR-folded into rb_parity.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               begin a load (sampled in IDLE only)
//   abort               terminate an active load (LOAD/SHIFT)
//   word_valid/ready    configuration word handshake
//   word_data           configuration word, bit 0 shifted first
//   sc_head             serial data into the first chain cell
//   sc_shift_en         chain cells capture sc_head at this edge
//   sc_tail             Q of the last chain cell
//   busy                load in progress
//   done                one-cycle pulse after CHAIN_LEN bits
//   aborted             one-cycle pulse after an abort
//   rb_parity           XOR of sc_tail over the shift cycles of the last load

module sc_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              sc_head,
    output logic              sc_shift_en,
    input  logic              sc_tail,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              rb_parity
);

    localparam int WC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_sreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic              r_ready;
    logic              r_shift;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic              r_parity;

    logic w_abort_act;
    logic w_last_bit;
    logic w_last_word_bit;

    assign w_abort_act     = abort && (r_state == S_LOAD || r_state == S_SHIFT);
    assign w_last_bit      = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_last_word_bit = (r_word_cnt == WC_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_ready    <= 1'b0;
            r_shift    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_parity   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= '0;
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_parity <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (word_valid) begin
                        r_sreg     <= word_data;
                        r_word_cnt <= '0;
                        r_state    <= S_SHIFT;
                        r_ready    <= 1'b0;
                        r_shift    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        // The gated shift enable means this edge never shifted,
                        // so counters and parity stay untouched.
                        r_state   <= S_IDLE;
                        r_shift   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_sreg     <= r_sreg >> 1;
                        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                        r_word_cnt <= r_word_cnt + WC_W'(1);
                        r_parity   <= r_parity ^ sc_tail;
                        // Chain length is checked first so a partial final
                        // word drops its unused upper bits.
                        if (w_last_bit) begin
                            r_state <= S_DONE;
                            r_shift <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_last_word_bit) begin
                            r_state <= S_LOAD;
                            r_shift <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_shift <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready  = r_ready;
    assign sc_head     = r_sreg[0];
    // Abort must stop the chain in the very cycle it is raised.
    assign sc_shift_en = r_shift && !w_abort_act;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign rb_parity   = r_parity;

endmodule

// File: tb/tb_sc_chain_loader.sv
// tb/tb_sc_chain_loader.sv - self-checking bench for sc_chain_loader
module tb_sc_chain_loader;

    typedef struct packed {
        bit       rst;
        bit       start;
        bit       abort;
        bit       valid;
        bit       tail;
        bit [3:0] data;
        bit       e_ready;
        bit       e_en;
        bit       e_head;
        bit       chk_head;
        bit       e_busy;
        bit       e_done;
        bit       e_abt;
        bit       e_par;
    } step_t;

    logic       clk = 1'b0;
    logic [1:0] t_reset, t_start, t_abort, t_valid, t_tail;
    logic [3:0] t_data0, t_data1;
    logic [1:0] o_ready, o_head, o_en, o_busy, o_done, o_abt, o_par;

    always #5 clk = ~clk;

    sc_chain_loader #(.CHAIN_LEN(10), .WORD_W(4), .CNT_W(16)) u_dut10 (
        .clk(clk), .reset(t_reset[0]), .start(t_start[0]), .abort(t_abort[0]),
        .word_valid(t_valid[0]), .word_data(t_data0), .word_ready(o_ready[0]),
        .sc_head(o_head[0]), .sc_shift_en(o_en[0]), .sc_tail(t_tail[0]),
        .busy(o_busy[0]), .done(o_done[0]), .aborted(o_abt[0]), .rb_parity(o_par[0])
    );

    sc_chain_loader #(.CHAIN_LEN(8), .WORD_W(4), .CNT_W(16)) u_dut8 (
        .clk(clk), .reset(t_reset[1]), .start(t_start[1]), .abort(t_abort[1]),
        .word_valid(t_valid[1]), .word_data(t_data1), .word_ready(o_ready[1]),
        .sc_head(o_head[1]), .sc_shift_en(o_en[1]), .sc_tail(t_tail[1]),
        .busy(o_busy[1]), .done(o_done[1]), .aborted(o_abt[1]), .rb_parity(o_par[1])
    );

    int    n_pass = 0;
    int    n_tot  = 0;
    step_t tr[$];
    bit    m_par[2];
    // Per-run observations of the DUT, for literal checks.
    int    n_sh, n_hs, done_at, n_abt, n_rdy2;
    bit    heads[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic step_t base(input bit par);
        step_t s;
        s = '0;
        s.e_par = par;
        return s;
    endfunction

    // Expected trace of one load, derived from the word/stall/tail schedule.
    // abort_at / reset_at index the abortable cycles (stall and shift cycles).
    task automatic build(input int d, input int L, input bit [3:0] words[$],
                         input int stalls[$], input bit tails[$],
                         input int abort_at, input int reset_at, input bit noise);
        step_t s;
        int    ac = 0;
        int    sh = 0;
        int    nb;
        bit    par;
        bit    stop = 0;
        bit    was_rst = 0;
        tr.delete();
        s = base(m_par[d]);
        s.start = 1;
        s.abort = noise ? bit'($urandom % 2) : 1'b0;
        tr.push_back(s);
        par = 0;
        for (int k = 0; k < words.size() && !stop; k++) begin
            for (int j = 0; j < stalls[k] && !stop; j++) begin
                s = base(par);
                s.e_ready = 1; s.e_busy = 1;
                s.data = 4'($urandom);
                s.start = noise ? bit'($urandom % 2) : 1'b0;
                if (ac == abort_at) begin s.abort = 1; stop = 1; end
                else if (ac == reset_at) begin s.rst = 1; stop = 1; was_rst = 1; end
                tr.push_back(s);
                ac++;
            end
            if (stop) break;
            s = base(par);
            s.e_ready = 1; s.e_busy = 1; s.valid = 1; s.data = words[k];
            tr.push_back(s);
            nb = (L - sh < 4) ? (L - sh) : 4;
            for (int b = 0; b < nb; b++) begin
                s = base(par);
                s.e_busy = 1; s.e_en = 1; s.e_head = words[k][b]; s.chk_head = 1;
                s.tail = tails[sh];
                if (noise) begin
                    s.valid = bit'($urandom % 2);
                    s.start = bit'($urandom % 2);
                    s.data  = 4'($urandom);
                end
                if (ac == abort_at) begin
                    s.abort = 1; s.e_en = 0; s.chk_head = 0; stop = 1;
                end else if (ac == reset_at) begin
                    s.rst = 1; stop = 1; was_rst = 1;
                end
                tr.push_back(s);
                if (stop) break;
                par ^= tails[sh];
                sh++;
                ac++;
            end
        end
        if (!stop) begin
            s = base(par);
            s.e_busy = 1; s.e_done = 1;
            if (noise) begin s.abort = bit'($urandom % 2); s.start = bit'($urandom % 2); end
            tr.push_back(s);
        end else if (was_rst) begin
            par = 0;
            for (int j = 0; j < 3; j++) begin
                s = base(0);
                s.valid = 1; s.chk_head = 1; s.e_head = 0;
                tr.push_back(s);
            end
        end else begin
            s = base(par);
            s.e_abt = 1;
            tr.push_back(s);
        end
        m_par[d] = par;
    endtask

    task automatic apply(input int d, input step_t s);
        t_reset = '0; t_start = '0; t_abort = '0; t_valid = '0; t_tail = '0;
        t_data0 = '0; t_data1 = '0;
        t_reset[d] = s.rst; t_start[d] = s.start; t_abort[d] = s.abort;
        t_valid[d] = s.valid; t_tail[d] = s.tail;
        if (d == 0) t_data0 = s.data; else t_data1 = s.data;
    endtask

    task automatic run(input int d);
        n_sh = 0; n_hs = 0; done_at = -1; n_abt = 0; n_rdy2 = 0;
        heads.delete();
        foreach (tr[i]) begin
            @(posedge clk); #1;
            apply(d, tr[i]);
            @(negedge clk);
            chk("word_ready", int'(o_ready[d]), int'(tr[i].e_ready));
            chk("sc_shift_en", int'(o_en[d]), int'(tr[i].e_en));
            chk("busy", int'(o_busy[d]), int'(tr[i].e_busy));
            chk("done", int'(o_done[d]), int'(tr[i].e_done));
            chk("aborted", int'(o_abt[d]), int'(tr[i].e_abt));
            chk("rb_parity", int'(o_par[d]), int'(tr[i].e_par));
            if (tr[i].chk_head) chk("sc_head", int'(o_head[d]), int'(tr[i].e_head));
            if (o_en[d]) begin n_sh++; heads.push_back(o_head[d]); end
            if (n_hs >= 2 && o_ready[d]) n_rdy2++;
            if (o_ready[d] && tr[i].valid) n_hs++;
            if (o_done[d] && done_at < 0) done_at = i;
            if (o_abt[d]) n_abt++;
        end
        @(posedge clk); #1;
        apply(d, base(0));
    endtask

    initial begin
        bit [3:0] w[$];
        int       st[$];
        bit       tl[$];
        int       exp_seq[10] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
        int       L, nw, ab, rs;

        t_reset = 2'b11; t_start = '0; t_abort = '0; t_valid = '0; t_tail = '0;
        t_data0 = '0; t_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst word_ready", int'(o_ready[d]), 0);
            chk("rst sc_head", int'(o_head[d]), 0);
            chk("rst sc_shift_en", int'(o_en[d]), 0);
            chk("rst busy", int'(o_busy[d]), 0);
            chk("rst done", int'(o_done[d]), 0);
            chk("rst aborted", int'(o_abt[d]), 0);
            chk("rst rb_parity", int'(o_par[d]), 0);
        end
        @(posedge clk); #1;
        t_reset = '0;
        m_par[0] = 0; m_par[1] = 0;

        // Basic load, tail tied high.
        w = '{4'hA, 4'h5, 4'h3}; st = '{0, 0, 0};
        tl = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        build(0, 10, w, st, tl, -1, -1, 0);
        chk("model basic length", tr.size(), 15);
        chk("model basic done step", int'(tr[14].e_done), 1);
        run(0);
        chk("basic shifts", n_sh, 10);
        chk("basic handshakes", n_hs, 3);
        chk("basic done cycle", done_at, 14);
        chk("basic parity", int'(o_par[0]), 0);
        chk("basic head count", heads.size(), 10);
        for (int i = 0; i < 10 && i < heads.size(); i++)
            chk($sformatf("basic head[%0d]", i), int'(heads[i]), exp_seq[i]);

        // Stalled source, seven ones on the tail.
        st = '{0, 5, 0};
        tl = '{1, 1, 1, 0, 1, 0, 1, 1, 0, 1};
        build(0, 10, w, st, tl, -1, -1, 0);
        run(0);
        chk("stall shifts", n_sh, 10);
        chk("stall done cycle", done_at, 19);
        chk("stall parity", int'(o_par[0]), 1);
        for (int i = 0; i < 10 && i < heads.size(); i++)
            chk($sformatf("stall head[%0d]", i), int'(heads[i]), exp_seq[i]);

        // Next start clears parity (model expects 0 from the first LOAD cycle).
        st = '{0, 0, 0};
        build(0, 10, w, st, tl, 5, -1, 0);
        chk("model parity cleared", int'(tr[1].e_par), 0);
        run(0);
        chk("abort shifts", n_sh, 5);
        chk("abort pulses", n_abt, 1);
        chk("abort no done", done_at, -1);

        // Full load after abort.
        build(0, 10, w, st, tl, -1, -1, 0);
        run(0);
        chk("post-abort shifts", n_sh, 10);
        chk("post-abort done cycle", done_at, 14);

        // Reset on the third shift.
        build(0, 10, w, st, tl, -1, 2, 0);
        run(0);
        chk("reset shifts", n_sh, 3);
        chk("reset no done", done_at, -1);

        // Exact multiple: CHAIN_LEN=8.
        w = '{4'hF, 4'h0}; st = '{0, 0};
        tl = '{0, 1, 0, 0, 1, 1, 0, 1};
        build(1, 8, w, st, tl, -1, -1, 0);
        run(1);
        chk("exact shifts", n_sh, 8);
        chk("exact handshakes", n_hs, 2);
        chk("exact ready after 2nd", n_rdy2, 0);
        chk("exact done cycle", done_at, 11);

        // Randomized loads on both instances.
        for (int it = 0; it < 60; it++) begin
            int d;
            d  = it % 2;
            L  = (d == 0) ? 10 : 8;
            nw = (L + 3) / 4;
            w.delete(); st.delete(); tl.delete();
            for (int k = 0; k < nw; k++) begin
                w.push_back(4'($urandom));
                st.push_back(($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0);
            end
            for (int k = 0; k < L; k++) tl.push_back(bit'($urandom % 2));
            ab = ($urandom % 4 == 0) ? int'($urandom_range(0, L + 3)) : -1;
            rs = (ab < 0 && $urandom % 8 == 0) ? int'($urandom_range(0, L + 3)) : -1;
            build(d, L, w, st, tl, ab, rs, 1);
            run(d);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
